instruction_fetch_unit: RTL and testbench
=========================================

Name:
instruction_fetch_unit

Overview:
- Fetch stage upstream of the instruction memory. Owns the PC and drives the memory's word address.
- Captures the returned instruction with its PC into a small fetch queue.
- Presents queued entries to decode over a valid/ready handshake.
- Handles branch/jump redirects (queue flush) and fetch faults (misaligned or out-of-window PC).

Parameters:
- RESET_PC, 32'h00400000, PC loaded on clear.
- IMEM_BASE, 32'h00400000, first byte address of the instruction window.
- IMEM_WORDS, 256, window size in 32-bit words; window is [IMEM_BASE, IMEM_BASE+4*IMEM_WORDS).
- DEPTH, 4, fetch-queue entries (power of two, >=2).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- clear  in  1  synchronous, active-high reset.
- imem_address  out  32  byte address to instruction memory; always equals pc.
- imem_instr  in  32  instruction memory read data, valid combinationally in the same cycle as imem_address.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- count  out  $clog2(DEPTH)+1  current queue occupancy.
- fault  out  1  fetch fault latched.
- fault_pc  out  32  offending address.

Behaviour:
- States: RUN, FAULT. On clear (sync): state=RUN, pc=RESET_PC, queue emptied (count=0, out_valid=0), fault=0, fault_pc=0. Clear overrides every other input in the same cycle.
- imem_address=pc combinationally at all times. pc is in-window iff IMEM_BASE <= pc < IMEM_BASE+4*IMEM_WORDS and pc[1:0]==0.
- pop = out_valid & out_ready. out_instr/out_pc show the head entry; they are don't-care when out_valid=0.
- push occurs when state=RUN, redirect=0, pc in-window, and (count<DEPTH or pop). On push, {pc, imem_instr} is written at the tail and pc<=pc+4. One push per cycle max.
- Simultaneous push and pop when full: both occur, count unchanged. Push and pop when empty: the pushed entry becomes visible the next cycle (no bypass; latency from pc to out_valid is 1 cycle).
- count<=count+push-pop; read/write pointers wrap modulo DEPTH.
- Redirect (highest priority below clear), in any state:
  - Queue is flushed (count=0, out_valid=0 next cycle).
  - A pop in the same cycle is still counted as accepted by decode; the flush discards the remaining entries.
  - No push that cycle.
  - If redirect_pc is in-window: pc<=redirect_pc, state<=RUN, fault<=0.
  - Else: state<=FAULT, fault<=1, fault_pc<=redirect_pc, pc<=redirect_pc.
- Sequential fault: in RUN with redirect=0 and pc not in-window (e.g. ran past window end): state<=FAULT, fault<=1, fault_pc<=pc, no push.
  - Entries already queued still drain normally.
- FAULT: no pushes, pc held, fault stays 1 until clear or an in-window redirect.
- pc arithmetic is 32-bit modulo; wrap at 32'hFFFFFFFC yields an out-of-window address and therefore a fault.

Test Plan:
- Reset then out_ready=1 with memory words 0x00220018, 0x0041001A, 0x00001810 -> out_valid rises 1 cycle after clear release; out_pc 0x00400000, 0x00400004, 0x00400008 with matching instructions, one per cycle.
- out_ready=0 for 10 cycles -> count saturates at 4, pc holds at 0x00400010. Then out_ready=1 -> entries 0x00400000..0x0040000C emerge in order with no loss or duplication; simultaneous push/pop keeps count=4.
- Redirect to 0x00400020 while count=3 and pop asserted -> next cycle count=0, out_valid=0; the cycle after, out_pc=0x00400020.
- Redirect to 0x00400022 -> fault=1, fault_pc=0x00400022, no further out_valid. Then redirect to 0x00400000 -> fault=0, fetch resumes from 0x00400000.
- Redirect to 0x004003FC with out_ready=1 -> one entry at 0x004003FC, then fault=1 with fault_pc=0x00400400; the queued entry still drains.
- Assert clear while count=2 and in FAULT -> next cycle count=0, fault=0, pc=0x00400000, state RUN.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage sitting in front of the instruction memory. It owns the PC,
// drives the memory word address straight from it, captures the returned
// instruction together with its PC into a small circular fetch queue, and
// hands queued entries to decode over a valid/ready handshake. Taken
// branches/jumps flush the queue and redirect the PC; a PC that is
// misaligned or outside the instruction window raises a latched fault.
//
// Ports:
//   clock        in   1   single clock, all state changes on posedge
//   clear        in   1   synchronous active-high reset
//   imem_address out  32  byte address to instruction memory (= pc)
//   imem_instr   in  32   memory read data, combinational from imem_address
//   redirect     in   1   taken branch/jump this cycle
//   redirect_pc  in  32   redirect target byte address
//   out_valid    out  1   queue head valid
//   out_ready    in   1   decode accepts the head entry
//   out_instr    out 32   head instruction
//   out_pc       out 32   head PC
//   count        out CW   current queue occupancy, CW = $clog2(DEPTH)+1
//   fault        out  1   fetch fault latched
//   fault_pc     out 32   offending address of the latched fault
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter logic [31:0] IMEM_BASE  = 32'h00400000,
    parameter int          IMEM_WORDS = 256,
    parameter int          DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    output logic [31:0]              imem_address,
    input  logic [31:0]              imem_instr,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fault,
    output logic [31:0]              fault_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Window bounds held in 33 bits so a window ending exactly at 4 GiB
    // does not wrap the upper bound back to a small number.
    localparam logic [32:0] WIN_LO = {1'b0, IMEM_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * IMEM_WORDS);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Address qualification
    // -----------------------------------------------------------------------
    function automatic logic in_window(input logic [31:0] addr);
        logic [32:0] addr33;
        addr33 = {1'b0, addr};
        return (addr[1:0] == 2'b00) && (addr33 >= WIN_LO) && (addr33 < WIN_HI);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fault_q, fault_d;
    logic [31:0]        fault_pc_q, fault_pc_d;

    // Queue storage: data only, never reset (occupancy tracks validity).
    logic [31:0]        q_instr_q [DEPTH];
    logic [31:0]        q_pc_q    [DEPTH];

    logic               push;
    logic               pop;
    logic               pc_ok;
    logic               has_room;

    assign pc_ok    = in_window(pc_q);
    assign has_room = (count_q < CNT_W'(DEPTH));

    assign out_valid    = (count_q != '0);
    assign pop          = out_valid & out_ready;
    assign out_instr    = q_instr_q[rptr_q];
    assign out_pc       = q_pc_q[rptr_q];
    assign count        = count_q;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;
    assign imem_address = pc_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;

        if (redirect) begin
            // Flush: a pop this cycle was already taken by decode, so simply
            // dropping every entry (and realigning the pointers) is correct.
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            pc_d    = redirect_pc;
            if (in_window(redirect_pc)) begin
                state_d = RUN;
                fault_d = 1'b0;
            end else begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (pc_ok) begin
                        // A pop frees the head slot in the same cycle, so a
                        // full queue can still accept a new word.
                        if (has_room || pop) begin
                            push   = 1'b1;
                            pc_d   = pc_q + 32'd4;
                            wptr_d = wptr_q + PTR_W'(1);
                        end
                    end else begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end
                end
                FAULT: begin
                    // PC held; queued entries keep draining below.
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Queue storage write
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            q_instr_q[wptr_q] <= imem_instr;
            q_pc_q[wptr_q]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] imem_address;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;
    logic        fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .clock        (clock),
        .clear        (clear),
        .imem_address (imem_address),
        .imem_instr   (imem_instr),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .count        (count),
        .fault        (fault),
        .fault_pc     (fault_pc)
    );

    always #5 clock = ~clock;

    // Instruction memory model: word 0..2 from the test plan, others 0x10000000+index.
    logic [31:0] imem [256];
    logic [31:0] off;
    always_comb begin
        off = imem_address - 32'h00400000;
        if (off < 32'd1024) imem_instr = imem[off[9:2]];
        else                imem_instr = 32'hDEADBEEF;
    end

    typedef struct {
        logic        clr;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [2:0]  ecnt;
        logic        eflt;
        logic [31:0] efpc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic clr, input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                       input logic [2:0] ecnt, input logic eflt, input logic [31:0] efpc,
                       input logic [31:0] eaddr);
        vec_t v;
        v.clr = clr; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.ecnt = ecnt;
        v.eflt = eflt; v.efpc = efpc; v.eaddr = eaddr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h10000000 + 32'(i);
        imem[0] = 32'h00220018;
        imem[1] = 32'h0041001A;
        imem[2] = 32'h00001810;

        //   clr rd rpc           rdy  ev epc           einstr        cnt flt fpc           addr
        // basic streaming after reset
        add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0,  0, 32'h0,        32'h00400000);
        add(0, 0, 32'h0,        1,   1, 32'h00400000, 32'h00220018, 1,  0, 32'h0,        32'h00400004);
        add(0, 0, 32'h0,        1,   1, 32'h00400004, 32'h0041001A, 1,  0, 32'h0,        32'h00400008);
        add(1, 0, 32'h0,        1,   1, 32'h00400008, 32'h00001810, 1,  0, 32'h0,        32'h0040000C);
        // decode stalled for 10 cycles: fill to 4, pc holds
        add(0, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0,  0, 32'h0,        32'h00400000);
        add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00220018, 1,  0, 32'h0,        32'h00400004);
        add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00220018, 2,  0, 32'h0,        32'h00400008);
        add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00220018, 3,  0, 32'h0,        32'h0040000C);
        for (int i = 0; i < 6; i++)
            add(0, 0, 32'h0,    0,   1, 32'h00400000, 32'h00220018, 4,  0, 32'h0,        32'h00400010);
        // drain in order with push+pop at full
        add(0, 0, 32'h0,        1,   1, 32'h00400000, 32'h00220018, 4,  0, 32'h0,        32'h00400010);
        add(0, 0, 32'h0,        1,   1, 32'h00400004, 32'h0041001A, 4,  0, 32'h0,        32'h00400014);
        add(0, 0, 32'h0,        1,   1, 32'h00400008, 32'h00001810, 4,  0, 32'h0,        32'h00400018);
        add(0, 0, 32'h0,        1,   1, 32'h0040000C, 32'h10000003, 4,  0, 32'h0,        32'h0040001C);
        add(0, 0, 32'h0,        1,   1, 32'h00400010, 32'h10000004, 4,  0, 32'h0,        32'h00400020);
        // redirect with count=3 and pop
        add(1, 0, 32'h0,        0,   1, 32'h00400014, 32'h10000005, 4,  0, 32'h0,        32'h00400024);
        add(0, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0,  0, 32'h0,        32'h00400000);
        add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00220018, 1,  0, 32'h0,        32'h00400004);
        add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00220018, 2,  0, 32'h0,        32'h00400008);
        add(0, 1, 32'h00400020, 1,   1, 32'h00400000, 32'h00220018, 3,  0, 32'h0,        32'h0040000C);
        add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0,  0, 32'h0,        32'h00400020);
        add(0, 0, 32'h0,        1,   1, 32'h00400020, 32'h10000008, 1,  0, 32'h0,        32'h00400024);
        // misaligned redirect faults, in-window redirect recovers
        add(0, 1, 32'h00400022, 1,   1, 32'h00400024, 32'h10000009, 1,  0, 32'h0,        32'h00400028);
        add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0,  1, 32'h00400022, 32'h00400022);
        add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0,  1, 32'h00400022, 32'h00400022);
        add(0, 1, 32'h00400000, 1,   0, 32'h0,        32'h0,        0,  1, 32'h00400022, 32'h00400022);
        add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0,  0, 32'h00400022, 32'h00400000);
        add(0, 0, 32'h0,        1,   1, 32'h00400000, 32'h00220018, 1,  0, 32'h00400022, 32'h00400004);
        // last window word, then sequential fault past the end; entry drains
        add(0, 1, 32'h004003FC, 1,   1, 32'h00400004, 32'h0041001A, 1,  0, 32'h00400022, 32'h00400008);
        add(0, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0,  0, 32'h00400022, 32'h004003FC);
        add(0, 0, 32'h0,        0,   1, 32'h004003FC, 32'h100000FF, 1,  0, 32'h00400022, 32'h00400400);
        add(0, 0, 32'h0,        0,   1, 32'h004003FC, 32'h100000FF, 1,  1, 32'h00400400, 32'h00400400);
        add(0, 0, 32'h0,        1,   1, 32'h004003FC, 32'h100000FF, 1,  1, 32'h00400400, 32'h00400400);
        add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0,  1, 32'h00400400, 32'h00400400);
        // clear while count=2 and in FAULT
        add(0, 1, 32'h004003F8, 0,   0, 32'h0,        32'h0,        0,  1, 32'h00400400, 32'h00400400);
        add(0, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0,  0, 32'h00400400, 32'h004003F8);
        add(0, 0, 32'h0,        0,   1, 32'h004003F8, 32'h100000FE, 1,  0, 32'h00400400, 32'h004003FC);
        add(0, 0, 32'h0,        0,   1, 32'h004003F8, 32'h100000FE, 2,  0, 32'h00400400, 32'h00400400);
        add(1, 0, 32'h0,        0,   1, 32'h004003F8, 32'h100000FE, 2,  1, 32'h00400400, 32'h00400400);
        add(0, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0,  0, 32'h0,        32'h00400000);
        // redirect below the window base
        add(0, 1, 32'h003FFFFC, 0,   1, 32'h00400000, 32'h00220018, 1,  0, 32'h0,        32'h00400004);
        add(0, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0,  1, 32'h003FFFFC, 32'h003FFFFC);

        clear = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        foreach (vq[r]) begin
            clear       = vq[r].clr;
            redirect    = vq[r].rd;
            redirect_pc = vq[r].rpc;
            out_ready   = vq[r].rdy;
            #1;
            chk("out_valid", r, 32'(out_valid), 32'(vq[r].ev));
            chk("count",     r, 32'(count),     32'(vq[r].ecnt));
            chk("fault",     r, 32'(fault),     32'(vq[r].eflt));
            chk("fault_pc",  r, fault_pc,       vq[r].efpc);
            chk("imem_addr", r, imem_address,   vq[r].eaddr);
            if (vq[r].ev) begin
                chk("out_pc",    r, out_pc,    vq[r].epc);
                chk("out_instr", r, out_instr, vq[r].einstr);
            end
            @(posedge clock);
            #1;
        end

        // Hand sequence: intermittent ready, every accepted entry must be the
        // next sequential PC with its memory word, with no gaps or repeats.
        begin
            logic [31:0] exp_pc;
            int pops;
            exp_pc = 32'h00400000;
            pops = 0;
            clear = 1'b1; redirect = 1'b0; out_ready = 1'b0;
            @(posedge clock);
            #1;
            clear = 1'b0;
            for (int c = 0; c < 30; c++) begin
                out_ready = (c % 3) != 0;
                #1;
                if (out_valid && out_ready) begin
                    chk("seq_pc",    1000 + c, out_pc,    exp_pc);
                    chk("seq_instr", 1000 + c, out_instr, imem[(exp_pc - 32'h00400000) >> 2]);
                    exp_pc += 32'd4;
                    pops++;
                end
                @(posedge clock);
                #1;
            end
            chk("seq_pops", 2000, 32'(pops), 32'd20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
